// File: rtl/spatial_channel_sequencer.sv
// spatial_channel_sequencer: takes one packed multi-channel sample, then walks
// the channels one per enabled cycle and drives the spatial accumulator strobes.
// After the last channel it holds HvValid_SO until the downstream stage accepts.
// Optional macro SEQ_SAMPLE_COUNT_EN adds a 16-bit count of completed samples.
module spatial_channel_sequencer #(
  parameter int NUM_CHANNELS  = 217,
  parameter int CHANNEL_WIDTH = 2,
  parameter int IDX_WIDTH     = 8
) (
  input  logic                                  Clk_CI,
  input  logic                                  Reset_RI,
  input  logic                                  SampleValid_SI,
  output logic                                  SampleReady_SO,
  input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] SampleIn_DI,
  input  logic                                  ItemReady_SI,
  output logic [IDX_WIDTH-1:0]                  ChannelIdx_DO,
  output logic [CHANNEL_WIDTH-1:0]              FeatureOut_DO,
  output logic                                  AccEnable_SO,
  output logic                                  FirstHypervector_SO,
  output logic                                  StoreSecond_SO,
  output logic                                  XorFinal_SO,
  output logic                                  HvValid_SO,
  input  logic                                  HvReady_SI,
`ifdef SEQ_SAMPLE_COUNT_EN
  output logic [15:0]                           SampleCount_DO,
`endif
  output logic                                  Busy_SO
);

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_e;

  localparam int                   IDX_SPAN = 2 ** IDX_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CHANNELS - 1);

  state_e                                state_q, state_d;
  logic [IDX_WIDTH-1:0]                  idx_q, idx_d;
  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] sample_q, sample_d;
  logic                                  accept;

  // Channel view of the latched sample, padded to the full index range so the
  // feature mux needs no range handling; padding entries are never selected.
  logic [CHANNEL_WIDTH-1:0] chan [IDX_SPAN];
  for (genvar c = 0; c < IDX_SPAN; c++) begin : g_chan
    if (c < NUM_CHANNELS) begin : g_real
      assign chan[c] = sample_q[c*CHANNEL_WIDTH +: CHANNEL_WIDTH];
    end else begin : g_pad
      assign chan[c] = '0;
    end
  end

  // State, index and sample registers with synchronous active-low reset
  always_ff @(posedge Clk_CI) begin
    if (!Reset_RI) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sample_q <= sample_d;
    end
  end

  // Next state: accept a sample, step on enabled cycles, release on handshake
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sample_d = sample_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = RUN;
          idx_d    = '0;
          sample_d = SampleIn_DI;
        end
      end
      RUN: begin
        if (AccEnable_SO) begin
          if (idx_q == LAST_IDX) state_d = OUT;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      OUT: begin
        if (HvReady_SI) begin
          if (accept) begin
            state_d  = RUN;
            idx_d    = '0;
            sample_d = SampleIn_DI;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: handshake, accumulator strobes and status decoded from state
  always_comb begin
    SampleReady_SO      = (state_q == IDLE) || ((state_q == OUT) && HvReady_SI);
    accept              = SampleValid_SI && SampleReady_SO;
    ChannelIdx_DO       = idx_q;
    FeatureOut_DO       = chan[idx_q];
    AccEnable_SO        = (state_q == RUN) && ItemReady_SI;
    FirstHypervector_SO = AccEnable_SO && (idx_q == '0);
    StoreSecond_SO      = AccEnable_SO && (idx_q == IDX_WIDTH'(1));
    XorFinal_SO         = AccEnable_SO && (idx_q == LAST_IDX);
    HvValid_SO          = (state_q == OUT);
    Busy_SO             = (state_q != IDLE);
  end

`ifdef SEQ_SAMPLE_COUNT_EN
  logic [15:0] cnt_q;

  // Count completed hypervector handshakes, wrapping naturally at 16 bits
  always_ff @(posedge Clk_CI) begin
    if (!Reset_RI)                     cnt_q <= '0;
    else if (HvValid_SO && HvReady_SI) cnt_q <= cnt_q + 16'd1;
  end

  assign SampleCount_DO = cnt_q;
`endif

endmodule

// File: tb/tb_spatial_channel_sequencer.sv
// Directed bench for spatial_channel_sequencer with NUM_CHANNELS=4.
// Inputs change 1 time unit after the rising edge; outputs are checked 2 units later.
module tb_spatial_channel_sequencer;
  localparam int NC = 4;
  localparam int CW = 2;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst_n, sv, ir, hr;
  logic [NC*CW-1:0] din;
  logic          rdy, acc, first, store, xorf, hv, busy;
  logic [IW-1:0] idx;
  logic [CW-1:0] feat;
`ifdef SEQ_SAMPLE_COUNT_EN
  logic [15:0]   cnt;
`endif

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  spatial_channel_sequencer #(.NUM_CHANNELS(NC), .CHANNEL_WIDTH(CW), .IDX_WIDTH(IW)) dut (
    .Clk_CI(clk), .Reset_RI(rst_n),
    .SampleValid_SI(sv), .SampleReady_SO(rdy), .SampleIn_DI(din),
    .ItemReady_SI(ir), .ChannelIdx_DO(idx), .FeatureOut_DO(feat),
    .AccEnable_SO(acc), .FirstHypervector_SO(first), .StoreSecond_SO(store),
    .XorFinal_SO(xorf), .HvValid_SO(hv), .HvReady_SI(hr),
`ifdef SEQ_SAMPLE_COUNT_EN
    .SampleCount_DO(cnt),
`endif
    .Busy_SO(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  // One full sample with ItemReady held high and an immediate downstream accept.
  task automatic run_one(input logic [NC*CW-1:0] s);
    logic [NC*CW-1:0] sv_s;
    sv_s = s;
    sv = 1'b1; din = s; ir = 1'b1; hr = 1'b0;
    settle;
    chk("ready_idle", rdy, 1);
    tick;
    sv = 1'b0; din = ~s;
    for (int k = 0; k < NC; k++) begin
      settle;
      chk("run_idx",   idx,   k);
      chk("run_feat",  feat,  sv_s[k*CW +: CW]);
      chk("run_acc",   acc,   1);
      chk("run_first", first, (k == 0));
      chk("run_store", store, (k == 1));
      chk("run_xor",   xorf,  (k == NC-1));
      chk("run_ready", rdy,   0);
      tick;
    end
    settle;
    chk("out_hv",  hv,  1);
    chk("out_acc", acc, 0);
    chk("out_rdy_nohr", rdy, 0);
    hr = 1'b1;
    settle;
    chk("out_rdy_hr", rdy, 1);
    tick;
    hr = 1'b0;
    settle;
    chk("idle_busy", busy, 0);
    chk("idle_hv",   hv,   0);
  endtask

  initial begin
    rst_n = 1'b0; sv = 1'b0; ir = 1'b0; hr = 1'b0; din = '0;
    repeat (2) tick;
    rst_n = 1'b1;
    settle;
    chk("rst_busy",  busy, 0);
    chk("rst_hv",    hv,   0);
    chk("rst_ready", rdy,  1);
    chk("rst_acc",   acc,  0);
    chk("rst_idx",   idx,  0);

    // ch3=2, ch2=1, ch1=0, ch0=1 -> features 1,0,1,2
    run_one(8'h91);
`ifdef SEQ_SAMPLE_COUNT_EN
    chk("count_one", cnt, 1);
`endif

    // Stall at idx2, with the input bus changed to all-2 during RUN
    sv = 1'b1; din = 8'h91; ir = 1'b1;
    tick;
    sv = 1'b0; din = 8'hAA;
    settle; chk("st_first0", first, 1); chk("st_feat0", feat, 1);
    tick;
    settle; chk("st_store1", store, 1); chk("st_feat1", feat, 0);
    tick;
    ir = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle;
      chk("stall_acc",  acc,  0);
      chk("stall_idx",  idx,  2);
      chk("stall_feat", feat, 1);
      chk("stall_strb", {first, store, xorf}, 0);
      tick;
    end
    ir = 1'b1;
    settle; chk("resume_acc", acc, 1); chk("resume_idx", idx, 2); chk("resume_feat", feat, 1);
    tick;
    settle; chk("st_xor3", xorf, 1); chk("st_feat3", feat, 2); chk("st_idx3", idx, 3);
    tick;

    // Hold in OUT for 5 cycles, then handshake with a back-to-back sample
    for (int k = 0; k < 5; k++) begin
      settle;
      chk("hold_hv",   hv,   1);
      chk("hold_rdy",  rdy,  0);
      chk("hold_busy", busy, 1);
      tick;
    end
    hr = 1'b1; sv = 1'b1; din = 8'h66;
    settle; chk("b2b_rdy", rdy, 1);
    tick;
    hr = 1'b0; sv = 1'b0; din = 8'h00;
    settle;
    chk("b2b_idx",   idx,   0);
    chk("b2b_first", first, 1);
    chk("b2b_feat",  feat,  2);
    chk("b2b_hv",    hv,    0);
`ifdef SEQ_SAMPLE_COUNT_EN
    chk("count_two", cnt, 2);
`endif
    tick;
    settle; chk("b2b_store", store, 1); chk("b2b_feat1", feat, 1);

    // Reset at idx1 of RUN aborts the walk
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    settle;
    chk("abort_acc",   acc,  0);
    chk("abort_strb",  {first, store, xorf}, 0);
    chk("abort_hv",    hv,   0);
    chk("abort_busy",  busy, 0);
    chk("abort_ready", rdy,  1);
    chk("abort_idx",   idx,  0);
`ifdef SEQ_SAMPLE_COUNT_EN
    chk("count_rst", cnt, 0);
`endif

    run_one(8'h1B);
    run_one(8'hE4);
    run_one(8'h3C);
`ifdef SEQ_SAMPLE_COUNT_EN
    chk("count_three", cnt, 3);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
